vend_sequencer: RTL and testbench



---
 rtl/vend_pkg.sv | 19 +
 rtl/vend_if.sv | 27 ++
 rtl/vend_change_picker.sv | 14 +
 rtl/vend_sequencer.sv | 117 +++++++++++
 tb/tb_vend_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared types, coin values and prices for the vending sequencer
package vend_pkg;
   localparam int CW = 6;
   typedef logic [CW-1:0] credit_t;
   typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;
   localparam credit_t MAX_CREDIT = 63;
   localparam credit_t COIN0_VAL = 1;
   localparam credit_t COIN1_VAL = 5;
   localparam credit_t COIN2_VAL = 10;
   localparam credit_t PRICE0 = 5;
   localparam credit_t PRICE1 = 10;
   localparam credit_t PRICE2 = 15;
   localparam credit_t PRICE3 = 20;
   localparam int TIMEOUT = 32;

   function automatic credit_t price_of(logic [3:0] sel);
      return sel[0] ? PRICE0 : sel[1] ? PRICE1 : sel[2] ? PRICE2 : sel[3] ? PRICE3 : '0;
   endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: front-panel and actuator signals of the vending sequencer; fault exists with VEND_DISP_TIMEOUT_EN
interface vend_if;
   import vend_pkg::*;
   logic [3:0] P;
   logic [2:0] D;
   logic       cancel;
   logic       disp_done;
   logic       hop_ready;
   logic [3:0] OUT;
   logic [2:0] VF;
   credit_t    credit;
   logic       busy;
   logic       short;
   logic       coin_rej;
`ifdef VEND_DISP_TIMEOUT_EN
   logic       fault;
   modport master (input P, D, cancel, disp_done, hop_ready,
                   output OUT, VF, credit, busy, short, coin_rej, fault);
   modport slave  (output P, D, cancel, disp_done, hop_ready,
                   input OUT, VF, credit, busy, short, coin_rej, fault);
`else
   modport master (input P, D, cancel, disp_done, hop_ready,
                   output OUT, VF, credit, busy, short, coin_rej);
   modport slave  (output P, D, cancel, disp_done, hop_ready,
                   input OUT, VF, credit, busy, short, coin_rej);
`endif
endinterface

// File: rtl/vend_change_picker.sv
// vend_change_picker: largest coin not exceeding the given credit
module vend_change_picker
   import vend_pkg::*;
(
   input  credit_t    credit,
   output logic [2:0] coin,
   output credit_t    value
);
   // greedy pick; COIN0_VAL is 1 so any nonzero credit resolves
   always_comb begin
      coin  = credit >= COIN2_VAL ? 3'b100 : credit >= COIN1_VAL ? 3'b010 : credit >= COIN0_VAL ? 3'b001 : 3'b000;
      value = coin[2] ? COIN2_VAL : coin[1] ? COIN1_VAL : coin[0] ? COIN0_VAL : '0;
   end
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: credit, dispense and change sequencing; VEND_DISP_TIMEOUT_EN adds a dispense timeout with refund
module vend_sequencer
   import vend_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   vend_if.master bus
);
   state_t      state, state_n;
   credit_t     credit_n, coin_val, price, credit_add, pick_val, vf_amt, vf_amt_n;
   logic [CW:0] sum;
   logic [3:0]  sel, out_n;
   logic [2:0]  vf_n, pick_coin;
   logic        over, multi, short_n, rej_n;
`ifdef VEND_DISP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT) + 1;
   logic [TW-1:0] cnt, cnt_n;
   credit_t       saved, saved_n;
   logic          fault_n;
`endif

   assign sel        = bus.P & (~bus.P + 4'd1);
   assign coin_val   = bus.D[0] ? COIN0_VAL : bus.D[1] ? COIN1_VAL : bus.D[2] ? COIN2_VAL : '0;
   assign sum        = {1'b0, bus.credit} + {1'b0, coin_val};
   assign over       = sum > {1'b0, MAX_CREDIT};
   assign multi      = (bus.D & (bus.D - 3'd1)) != 3'd0;
   assign credit_add = (bus.D != 3'd0 && !over) ? sum[CW-1:0] : bus.credit;
   assign price      = price_of(sel);
   assign vf_n       = state_n == CHANGE ? pick_coin : 3'b000;
   assign vf_amt_n   = state_n == CHANGE ? pick_val : '0;

   vend_change_picker picker (.credit(credit_n), .coin(pick_coin), .value(pick_val));

   // next state, credit and pulse outputs; the coin is folded in before the price compare
   always_comb begin
      state_n  = state;
      credit_n = bus.credit;
      out_n    = bus.OUT;
      short_n  = 1'b0;
      rej_n    = 1'b0;
`ifdef VEND_DISP_TIMEOUT_EN
      cnt_n    = '0;
      saved_n  = saved;
      fault_n  = 1'b0;
`endif
      if (state == IDLE) begin
         rej_n    = multi || (bus.D != 3'd0 && over);
         credit_n = credit_add;
         if (bus.cancel) begin
            if (credit_add != '0) state_n = CHANGE;
         end else if (sel != 4'd0) begin
            if (credit_add >= price) begin
               credit_n = credit_add - price;
               out_n    = sel;
               state_n  = DISPENSE;
`ifdef VEND_DISP_TIMEOUT_EN
               saved_n  = credit_add;
`endif
            end else short_n = 1'b1;
         end
      end else if (state == DISPENSE) begin
         rej_n = bus.D != 3'd0;
`ifdef VEND_DISP_TIMEOUT_EN
         cnt_n = cnt + 1'b1;
`endif
         if (bus.disp_done) begin
            out_n   = 4'd0;
            state_n = bus.credit != '0 ? CHANGE : IDLE;
         end
`ifdef VEND_DISP_TIMEOUT_EN
         else if (cnt == TW'(TIMEOUT - 1)) begin
            out_n    = 4'd0;
            credit_n = saved;
            fault_n  = 1'b1;
            state_n  = saved != '0 ? CHANGE : IDLE;
         end
`endif
      end else begin
         rej_n = bus.D != 3'd0;
         if (bus.VF != 3'd0 && bus.hop_ready) credit_n = bus.credit - vf_amt;
         if (credit_n == '0) state_n = IDLE;
      end
   end

   // all outputs registered; reset aborts any transaction and forgets credit
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         bus.credit   <= '0;
         bus.OUT      <= 4'd0;
         bus.VF       <= 3'd0;
         vf_amt       <= '0;
         bus.busy     <= 1'b0;
         bus.short    <= 1'b0;
         bus.coin_rej <= 1'b0;
`ifdef VEND_DISP_TIMEOUT_EN
         cnt          <= '0;
         saved        <= '0;
         bus.fault    <= 1'b0;
`endif
      end else begin
         state        <= state_n;
         bus.credit   <= credit_n;
         bus.OUT      <= out_n;
         bus.VF       <= vf_n;
         vf_amt       <= vf_amt_n;
         bus.busy     <= state_n != IDLE;
         bus.short    <= short_n;
         bus.coin_rej <= rej_n;
`ifdef VEND_DISP_TIMEOUT_EN
         cnt          <= cnt_n;
         saved        <= saved_n;
         bus.fault    <= fault_n;
`endif
      end
   end
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: scoreboard bench for vend_sequencer
module tb_vend_sequencer;
   import vend_pkg::*;

   typedef struct packed {logic [3:0] p; logic [2:0] d; logic c; logic dd; logic hr;} in_t;
   typedef struct packed {logic [3:0] out; logic [2:0] vf; credit_t credit; logic busy; logic sh; logic rej; logic flt;} exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flt;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   vend_if bus();
   vend_sequencer dut (.clock(clk), .reset(rst_n), .bus(bus));

`ifdef VEND_DISP_TIMEOUT_EN
   assign flt = bus.fault;
`else
   assign flt = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic exp_t obs();
      return exp_t'({bus.OUT, bus.VF, bus.credit, bus.busy, bus.short, bus.coin_rej, flt});
   endfunction

   function automatic in_t mk(logic [3:0] p, logic [2:0] d, logic c, logic dd, logic hr);
      return in_t'({p, d, c, dd, hr});
   endfunction

   function automatic exp_t e(logic [3:0] o, logic [2:0] v, int c, logic b, logic s, logic r, logic f);
      return exp_t'({o, v, credit_t'(c), b, s, r, f});
   endfunction

   function automatic logic [2:0] coin_for(int c);
      return c >= 10 ? 3'b100 : c >= 5 ? 3'b010 : c >= 1 ? 3'b001 : 3'b000;
   endfunction

   task automatic apply(in_t x);
      bus.P = x.p;
      bus.D = x.d;
      bus.cancel = x.c;
      bus.disp_done = x.dd;
      bus.hop_ready = x.hr;
   endtask

   task automatic do_reset();
      apply('0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      exp_t w;
      apply('0);
      sb.push_back(e(0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      w = sb.pop_front();
      checks++;
      if (obs() !== w) begin errors++; $display("FAIL reset: got %h want %h", obs(), w); end
      rst_n = 1'b1;
   endtask

   task automatic run_rows(string name, in_t ins[$], exp_t ex[$]);
      foreach (ins[k]) begin
         apply(ins[k]);
         sb.push_back(ex[k]);
         @(negedge clk);
         begin
            exp_t w;
            w = sb.pop_front();
            checks++;
            if (obs() !== w) begin errors++; $display("FAIL %s[%0d]: got %h want %h", name, k, obs(), w); end
         end
      end
   endtask

   task automatic test_short();
      do_reset();
      run_rows("short",
         '{mk(0, 3'b001, 0, 0, 0), mk(0, 3'b001, 0, 0, 0), mk(4'b0001, 0, 0, 0, 0), mk(0, 0, 0, 0, 0)},
         '{e(0, 0, 1, 0, 0, 0, 0), e(0, 0, 2, 0, 0, 0, 0), e(0, 0, 2, 0, 1, 0, 0), e(0, 0, 2, 0, 0, 0, 0)});
   endtask

   task automatic test_dispense();
      do_reset();
      run_rows("dispense",
         '{mk(0, 3'b010, 0, 0, 0), mk(4'b0001, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(4'b0010, 3'b100, 1, 0, 0),
           mk(0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0)},
         '{e(0, 0, 5, 0, 0, 0, 0), e(4'b0001, 0, 0, 1, 0, 0, 0), e(4'b0001, 0, 0, 1, 0, 0, 0), e(4'b0001, 0, 0, 1, 0, 1, 0),
           e(0, 0, 0, 0, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0)});
   endtask

   task automatic test_change();
      do_reset();
      run_rows("change",
         '{mk(0, 3'b100, 0, 0, 0), mk(0, 3'b010, 0, 0, 0), mk(0, 3'b001, 0, 0, 0), mk(4'b0100, 0, 0, 0, 0),
           mk(0, 0, 0, 1, 0), mk(0, 0, 0, 0, 0), mk(4'b0001, 3'b001, 1, 0, 0), mk(0, 0, 0, 0, 1)},
         '{e(0, 0, 10, 0, 0, 0, 0), e(0, 0, 15, 0, 0, 0, 0), e(0, 0, 16, 0, 0, 0, 0), e(4'b0100, 0, 1, 1, 0, 0, 0),
           e(0, 3'b001, 1, 1, 0, 0, 0), e(0, 3'b001, 1, 1, 0, 0, 0), e(0, 3'b001, 1, 1, 0, 1, 0), e(0, 0, 0, 0, 0, 0, 0)});
   endtask

   task automatic test_cancel();
      do_reset();
      run_rows("cancel",
         '{mk(0, 3'b100, 0, 0, 0), mk(4'b0010, 0, 1, 0, 0), mk(0, 0, 0, 0, 1), mk(0, 0, 1, 0, 0)},
         '{e(0, 0, 10, 0, 0, 0, 0), e(0, 3'b100, 10, 1, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0), e(0, 0, 0, 0, 0, 0, 0)});
   endtask

   task automatic test_bounds();
      in_t  ins[$];
      exp_t ex[$];
      int   cr;
      do_reset();
      ins.push_back(mk(0, 3'b110, 0, 0, 0));      ex.push_back(e(0, 0, 5, 0, 0, 1, 0));
      ins.push_back(mk(4'b0010, 3'b010, 0, 0, 0)); ex.push_back(e(4'b0010, 0, 0, 1, 0, 0, 0));
      ins.push_back(mk(0, 0, 0, 1, 0));           ex.push_back(e(0, 0, 0, 0, 0, 0, 0));
      cr = 0;
      for (int k = 0; k < 6; k++) begin cr += 10; ins.push_back(mk(0, 3'b100, 0, 0, 0)); ex.push_back(e(0, 0, cr, 0, 0, 0, 0)); end
      for (int k = 0; k < 3; k++) begin cr += 1; ins.push_back(mk(0, 3'b001, 0, 0, 0)); ex.push_back(e(0, 0, cr, 0, 0, 0, 0)); end
      ins.push_back(mk(0, 3'b001, 0, 0, 0));      ex.push_back(e(0, 0, 63, 0, 0, 1, 0));
      ins.push_back(mk(0, 3'b010, 0, 0, 0));      ex.push_back(e(0, 0, 63, 0, 0, 1, 0));
      ins.push_back(mk(0, 3'b011, 0, 0, 0));      ex.push_back(e(0, 0, 63, 0, 0, 1, 0));
      cr = 58;
      ins.push_back(mk(4'b1111, 0, 0, 0, 0));     ex.push_back(e(4'b0001, 0, cr, 1, 0, 0, 0));
      ins.push_back(mk(0, 0, 0, 1, 0));           ex.push_back(e(0, coin_for(cr), cr, 1, 0, 0, 0));
      while (cr > 0) begin
         cr -= coin_for(cr) == 3'b100 ? 10 : coin_for(cr) == 3'b010 ? 5 : 1;
         ins.push_back(mk(0, 0, 0, 0, 1));
         ex.push_back(e(0, coin_for(cr), cr, cr != 0, 0, 0, 0));
      end
      ins.push_back(mk(4'b0001, 0, 0, 0, 0));     ex.push_back(e(0, 0, 0, 0, 1, 0, 0));
      run_rows("bounds", ins, ex);
   endtask

   task automatic test_reset_mid_change();
      exp_t w;
      do_reset();
      run_rows("pre_abort", '{mk(0, 3'b100, 0, 0, 0), mk(0, 0, 1, 0, 0)},
         '{e(0, 0, 10, 0, 0, 0, 0), e(0, 3'b100, 10, 1, 0, 0, 0)});
      apply('0);
      #2;
      rst_n = 1'b0;
      sb.push_back(e(0, 0, 0, 0, 0, 0, 0));
      #1;
      w = sb.pop_front();
      checks++;
      if (obs() !== w) begin errors++; $display("FAIL async_abort: got %h want %h", obs(), w); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_dispense_wait();
      in_t  ins[$];
      exp_t ex[$];
      do_reset();
      ins.push_back(mk(0, 3'b100, 0, 0, 0)); ex.push_back(e(0, 0, 10, 0, 0, 0, 0));
      ins.push_back(mk(0, 3'b100, 0, 0, 0)); ex.push_back(e(0, 0, 20, 0, 0, 0, 0));
      ins.push_back(mk(4'b1000, 0, 0, 0, 0)); ex.push_back(e(4'b1000, 0, 0, 1, 0, 0, 0));
`ifdef VEND_DISP_TIMEOUT_EN
      for (int k = 0; k < 31; k++) begin ins.push_back(mk(0, 0, 0, 0, 0)); ex.push_back(e(4'b1000, 0, 0, 1, 0, 0, 0)); end
      ins.push_back(mk(0, 0, 0, 0, 0)); ex.push_back(e(0, 3'b100, 20, 1, 0, 0, 1));
      ins.push_back(mk(0, 0, 0, 0, 1)); ex.push_back(e(0, 3'b100, 10, 1, 0, 0, 0));
      ins.push_back(mk(0, 0, 0, 0, 1)); ex.push_back(e(0, 0, 0, 0, 0, 0, 0));
`else
      for (int k = 0; k < 40; k++) begin ins.push_back(mk(0, 0, 0, 0, 0)); ex.push_back(e(4'b1000, 0, 0, 1, 0, 0, 0)); end
      ins.push_back(mk(0, 0, 0, 1, 0)); ex.push_back(e(0, 0, 0, 0, 0, 0, 0));
`endif
      run_rows("disp_wait", ins, ex);
   endtask

   initial begin
      test_reset();
      test_short();
      test_dispense();
      test_change();
      test_cancel();
      test_bounds();
      test_reset_mid_change();
      test_dispense_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
